// File: rtl/ff5_wb.sv
// ff5_wb -- final SPU pipeline stage (writeback).
//
// Registers the even/odd pipe results coming out of FF4 and drives the two
// write ports of the 128 x 128-bit register file. Also turns FF4's taken
// branch indication into a one-cycle PC redirect, then squashes younger
// writebacks for SQUASH_CYCLES non-stalled issue cycles.
//
// Optional feature macro: WB_BYPASS_EN (adds a combinational forwarding
// lookup on the registered writeback ports).
//
// Handshake: there is no valid/ready pair. stall=1 freezes every stage
// register and forces both write enables low for that cycle; stall=0 means
// the iff5_* bundle is captured and appears on wb_* one cycle later.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall                     hold stage contents, no capture
//   iff5_*                    FF4 bundle (even/odd results, branch info)
//   wb_we/addr/data_e|o       RF write ports
//   wb_uid_e|o, wb_memory_addr_o  retired bundle information
//   pc_redirect, pc_target    one-cycle redirect pulse and its target
//   squashing                 high while the branch FSM is in SQUASH
//   collision_cnt             saturating count of suppressed even writes
//   qry_addr, fwd_hit, fwd_data   forwarding lookup (WB_BYPASS_EN only)
module ff5_wb #(
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [6:0]       iff5_rtaddr_e,
  input  logic             iff5_wreg_e,
  input  logic [127:0]     iff5_rt_e,
  input  logic [2:0]       iff5_uid_e,
  input  logic [6:0]       iff5_rtaddr_o,
  input  logic             iff5_wreg_o,
  input  logic [127:0]     iff5_rt_o,
  input  logic [2:0]       iff5_uid_o,
  input  logic [31:0]      iff5_memory_addr_o,
  input  logic             iff5_branch_flag,
  input  logic [31:0]      iff5_branch_target_addr,
  input  logic             iff5_is_in_delayslot,
`ifdef WB_BYPASS_EN
  input  logic [6:0]       qry_addr,
  output logic             fwd_hit,
  output logic [127:0]     fwd_data,
`endif
  output logic             wb_we_e,
  output logic [6:0]       wb_addr_e,
  output logic [127:0]     wb_data_e,
  output logic             wb_we_o,
  output logic [6:0]       wb_addr_o,
  output logic [127:0]     wb_data_o,
  output logic [2:0]       wb_uid_e,
  output logic [2:0]       wb_uid_o,
  output logic [31:0]      wb_memory_addr_o,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             squashing,
  output logic [CNT_W-1:0] collision_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SQUASH   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] sq_cnt, sq_cnt_nxt;
  logic       load_target;
  logic       squash_now;
  logic       collision;

  // Delay-slot bundles are architecturally older than the branch target
  // stream, so they always commit even inside the squash window.
  always_comb begin
    squash_now = (state == SQUASH) & ~iff5_is_in_delayslot;
    collision  = iff5_wreg_e & iff5_wreg_o &
                 (iff5_rtaddr_e == iff5_rtaddr_o) & ~squash_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sq_cnt <= 4'd0;
    end else begin
      state  <= state_nxt;
      sq_cnt <= sq_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sq_cnt_nxt  = sq_cnt;
    load_target = 1'b0;
    pc_redirect = 1'b0;
    squashing   = 1'b0;
    unique case (state)
      IDLE: begin
        if (iff5_branch_flag && !stall) begin
          state_nxt   = REDIRECT;
          load_target = 1'b1;
        end
      end
      REDIRECT: begin
        // The pulse lasts exactly one cycle; stall does not extend it.
        pc_redirect = 1'b1;
        if (SQUASH_CYCLES == 0) begin
          state_nxt = IDLE;
        end else begin
          state_nxt  = SQUASH;
          sq_cnt_nxt = 4'(SQUASH_CYCLES);
        end
      end
      SQUASH: begin
        squashing = 1'b1;
        if (!stall) begin
          if (sq_cnt <= 4'd1) begin
            state_nxt  = IDLE;
            sq_cnt_nxt = 4'd0;
          end else begin
            sq_cnt_nxt = sq_cnt - 4'd1;
          end
        end
      end
      default: begin
        state_nxt  = IDLE;
        sq_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we_e          <= 1'b0;
      wb_addr_e        <= 7'd0;
      wb_data_e        <= 128'd0;
      wb_we_o          <= 1'b0;
      wb_addr_o        <= 7'd0;
      wb_data_o        <= 128'd0;
      wb_uid_e         <= 3'd0;
      wb_uid_o         <= 3'd0;
      wb_memory_addr_o <= 32'd0;
      pc_target        <= 32'd0;
      collision_cnt    <= '0;
    end else if (stall) begin
      wb_we_e <= 1'b0;
      wb_we_o <= 1'b0;
    end else begin
      wb_addr_e        <= iff5_rtaddr_e;
      wb_data_e        <= iff5_rt_e;
      wb_uid_e         <= iff5_uid_e;
      wb_addr_o        <= iff5_rtaddr_o;
      wb_data_o        <= iff5_rt_o;
      wb_uid_o         <= iff5_uid_o;
      wb_memory_addr_o <= iff5_memory_addr_o;
      // Odd pipe wins a same-address collision.
      wb_we_e          <= iff5_wreg_e & ~squash_now & ~collision;
      wb_we_o          <= iff5_wreg_o & ~squash_now;
      if (collision && (collision_cnt != {CNT_W{1'b1}})) begin
        collision_cnt <= collision_cnt + 1'b1;
      end
    end
    // Target is captured on the branch edge only; it holds afterwards.
    if (!rst && load_target) begin
      pc_target <= iff5_branch_target_addr;
    end
  end

`ifdef WB_BYPASS_EN
  logic hit_o, hit_e;

  always_comb begin
    hit_o   = wb_we_o & (wb_addr_o == qry_addr);
    hit_e   = wb_we_e & (wb_addr_e == qry_addr);
    fwd_hit = hit_o | hit_e;
    if (hit_o) begin
      fwd_data = wb_data_o;
    end else if (hit_e) begin
      fwd_data = wb_data_e;
    end else begin
      fwd_data = 128'd0;
    end
  end
`endif

endmodule

// File: tb/tb_ff5_wb.sv
// Self-checking bench for ff5_wb (SQUASH_CYCLES=2, CNT_W=16).
// Directed bundles with random payloads; each driven bundle pushes its
// expected writeback record, which is popped and compared one cycle later.
module tb_ff5_wb;

  localparam int W = 310;

  logic         clk, rst, stall;
  logic [6:0]   iff5_rtaddr_e, iff5_rtaddr_o;
  logic         iff5_wreg_e, iff5_wreg_o;
  logic [127:0] iff5_rt_e, iff5_rt_o;
  logic [2:0]   iff5_uid_e, iff5_uid_o;
  logic [31:0]  iff5_memory_addr_o, iff5_branch_target_addr;
  logic         iff5_branch_flag, iff5_is_in_delayslot;
  logic         wb_we_e, wb_we_o;
  logic [6:0]   wb_addr_e, wb_addr_o;
  logic [127:0] wb_data_e, wb_data_o;
  logic [2:0]   wb_uid_e, wb_uid_o;
  logic [31:0]  wb_memory_addr_o, pc_target;
  logic         pc_redirect, squashing;
  logic [15:0]  collision_cnt;
`ifdef WB_BYPASS_EN
  logic [6:0]   qry_addr;
  logic         fwd_hit;
  logic [127:0] fwd_data;
`endif

  ff5_wb #(.SQUASH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .iff5_rtaddr_e(iff5_rtaddr_e), .iff5_wreg_e(iff5_wreg_e),
    .iff5_rt_e(iff5_rt_e), .iff5_uid_e(iff5_uid_e),
    .iff5_rtaddr_o(iff5_rtaddr_o), .iff5_wreg_o(iff5_wreg_o),
    .iff5_rt_o(iff5_rt_o), .iff5_uid_o(iff5_uid_o),
    .iff5_memory_addr_o(iff5_memory_addr_o),
    .iff5_branch_flag(iff5_branch_flag),
    .iff5_branch_target_addr(iff5_branch_target_addr),
    .iff5_is_in_delayslot(iff5_is_in_delayslot),
`ifdef WB_BYPASS_EN
    .qry_addr(qry_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
    .wb_we_e(wb_we_e), .wb_addr_e(wb_addr_e), .wb_data_e(wb_data_e),
    .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .wb_uid_e(wb_uid_e), .wb_uid_o(wb_uid_o),
    .wb_memory_addr_o(wb_memory_addr_o),
    .pc_redirect(pc_redirect), .pc_target(pc_target),
    .squashing(squashing), .collision_cnt(collision_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  // Fields held by the stage while stalled.
  logic [6:0]   hold_ae, hold_ao;
  logic [127:0] hold_de, hold_do;
  logic [2:0]   hold_ue, hold_uo;
  logic [31:0]  hold_ma;

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] obs_rec();
    return {wb_we_e, wb_addr_e, wb_data_e, wb_uid_e,
            wb_we_o, wb_addr_o, wb_data_o, wb_uid_o, wb_memory_addr_o};
  endfunction

  // ---------------- driver ----------------
  // Drives one bundle, pushes its expected writeback, then compares it
  // against the stage output one cycle later.
  task automatic drive(input string tag,
                       input logic [6:0] ae, input logic we,
                       input logic [6:0] ao, input logic wo,
                       input logic br, input logic [31:0] tgt,
                       input logic ds, input logic st,
                       input logic exp_e, input logic exp_o);
    logic [127:0] de, dodd;
    logic [2:0]   ue, uo;
    logic [31:0]  ma;
    de   = {$urandom, $urandom, $urandom, $urandom};
    dodd = {$urandom, $urandom, $urandom, $urandom};
    ue   = 3'($urandom_range(0, 7));
    uo   = 3'($urandom_range(0, 7));
    ma   = $urandom;
    iff5_rtaddr_e = ae; iff5_wreg_e = we; iff5_rt_e = de; iff5_uid_e = ue;
    iff5_rtaddr_o = ao; iff5_wreg_o = wo; iff5_rt_o = dodd; iff5_uid_o = uo;
    iff5_memory_addr_o = ma;
    iff5_branch_flag = br; iff5_branch_target_addr = tgt;
    iff5_is_in_delayslot = ds; stall = st;
    if (st) begin
      exp_q.push_back({1'b0, hold_ae, hold_de, hold_ue,
                       1'b0, hold_ao, hold_do, hold_uo, hold_ma});
    end else begin
      hold_ae = ae; hold_de = de; hold_ue = ue;
      hold_ao = ao; hold_do = dodd; hold_uo = uo; hold_ma = ma;
      exp_q.push_back({exp_e, ae, de, ue, exp_o, ao, dodd, uo, ma});
    end
    @(posedge clk); #1;
    if (exp_q.size() == 0) check({tag, "_q"}, W'(1), W'(0));
    else check(tag, obs_rec(), exp_q.pop_front());
  endtask

  task automatic idle_inputs();
    iff5_rtaddr_e = 0; iff5_wreg_e = 0; iff5_rt_e = 0; iff5_uid_e = 0;
    iff5_rtaddr_o = 0; iff5_wreg_o = 0; iff5_rt_o = 0; iff5_uid_o = 0;
    iff5_memory_addr_o = 0; iff5_branch_flag = 0;
    iff5_branch_target_addr = 0; iff5_is_in_delayslot = 0; stall = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_wb"}, obs_rec(), W'(0));
    check({tag, "_redir"}, W'(pc_redirect), W'(0));
    check({tag, "_tgt"}, W'(pc_target), W'(0));
    check({tag, "_sq"}, W'(squashing), W'(0));
    check({tag, "_ccnt"}, W'(collision_cnt), W'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
`ifdef WB_BYPASS_EN
    qry_addr = 0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    // Plain dual write.
    drive("dual", 7'd5, 1, 7'd6, 1, 0, 0, 0, 0, 1, 1);
    check("dual_redir", W'(pc_redirect), W'(0));
`ifdef WB_BYPASS_EN
    qry_addr = 7'd6; #1;
    check("fwd_odd", W'({fwd_hit, fwd_data}), W'({1'b1, hold_do}));
    qry_addr = 7'd5; #1;
    check("fwd_even", W'({fwd_hit, fwd_data}), W'({1'b1, hold_de}));
    qry_addr = 7'd7; #1;
    check("fwd_miss", W'({fwd_hit, fwd_data}), W'(0));
`endif

    // Same-address collision: odd wins.
    drive("coll", 7'd9, 1, 7'd9, 1, 0, 0, 0, 0, 0, 1);
    check("coll_cnt", W'(collision_cnt), W'(1));

    // Branch, squash window of two issue cycles.
    drive("br1", 7'd10, 1, 7'd31, 1, 1, 32'h100, 0, 0, 1, 1);
    check("br1_redir", W'(pc_redirect), W'(1));
    check("br1_tgt", W'(pc_target), W'(32'h100));
    drive("br1_rd", 7'd7, 1, 7'd0, 0, 0, 0, 0, 0, 1, 0);
    check("br1_redir_off", W'(pc_redirect), W'(0));
    check("br1_sq_on", W'(squashing), W'(1));
    drive("br1_r1", 7'd1, 1, 7'd0, 0, 0, 0, 0, 0, 0, 0);
    check("br1_sq_mid", W'(squashing), W'(1));
    drive("br1_r2", 7'd0, 0, 7'd2, 1, 0, 0, 0, 0, 0, 0);
    check("br1_sq_off", W'(squashing), W'(0));
    drive("br1_r3", 7'd3, 1, 7'd0, 0, 0, 0, 0, 0, 1, 0);
    check("br1_tgt_hold", W'(pc_target), W'(32'h100));

    // Delay-slot bundle commits inside the window and still consumes a slot.
    drive("br2", 7'd0, 0, 7'd0, 0, 1, 32'h200, 0, 0, 0, 0);
    check("br2_tgt", W'(pc_target), W'(32'h200));
    drive("br2_rd", 7'd0, 0, 7'd0, 0, 0, 0, 0, 0, 0, 0);
    drive("br2_ds", 7'd4, 1, 7'd8, 1, 0, 0, 1, 0, 1, 1);
    check("br2_ds_sq", W'(squashing), W'(1));
    drive("br2_sq", 7'd11, 1, 7'd0, 0, 0, 0, 0, 0, 0, 0);
    check("br2_sq_off", W'(squashing), W'(0));

    // Stall inside SQUASH, then a younger branch that must be ignored.
    drive("br3", 7'd0, 0, 7'd0, 0, 1, 32'h300, 0, 0, 0, 0);
    drive("br3_rd", 7'd0, 0, 7'd0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive("br3_stall", 7'd12, 1, 7'd12, 1, 0, 0, 0, 1, 0, 0);
      check("br3_stall_sq", W'({squashing, pc_redirect}), W'(2'b10));
    end
    check("br3_ccnt", W'(collision_cnt), W'(1));
    drive("br3_s1", 7'd13, 1, 7'd0, 0, 1, 32'h400, 0, 0, 0, 0);
    check("br3_s1_st", W'({squashing, pc_redirect}), W'(2'b10));
    drive("br3_s2", 7'd14, 1, 7'd0, 0, 0, 0, 0, 0, 0, 0);
    check("br3_s2_st", W'({squashing, pc_redirect}), W'(2'b00));
    drive("br3_post", 7'd15, 1, 7'd16, 1, 0, 0, 0, 0, 1, 1);
    check("br3_post_st", W'({squashing, pc_redirect}), W'(2'b00));
    check("br3_tgt", W'(pc_target), W'(32'h300));

    // Reset taken while in REDIRECT.
    drive("br4", 7'd20, 1, 7'd20, 1, 1, 32'h500, 0, 0, 0, 1);
    check("br4_redir", W'(pc_redirect), W'(1));
    check("br4_ccnt", W'(collision_cnt), W'(2));
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("rst_redir");
    hold_ae = 0; hold_ao = 0; hold_de = 0; hold_do = 0;
    hold_ue = 0; hold_uo = 0; hold_ma = 0;
    drive("after_rst", 7'd21, 1, 7'd22, 1, 0, 0, 0, 0, 1, 1);
    check("after_rst_st", W'({squashing, pc_redirect}), W'(2'b00));

    if (exp_q.size() != 0) check("q_empty", W'(exp_q.size()), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
